muldiv_seq_ctrl: RTL and testbench

- Sequencer for the iterative multiply/divide unit in the E stage of the 5-stage MIPS32 pipeline.
- Accepts MULT/MULTU/DIV/DIVU issues and steps the unit for a fixed cycle count, then pulses the HI/LO write.
- Stalls the pipeline for a second mul/div issue, or for an MFHI/MFLO in D, while a result is still outstanding.
- Sits between the control unit (E-stage decode) and the muldiv datapath / HI-LO register pair.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_cycle_cnt.sv | 27 ++
 rtl/muldiv_seq_ctrl.sv | 115 +++++++++++
 tb/tb_muldiv_seq_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the E-stage multiply/divide sequencer.
// State encoding, default iteration counts and op-select values.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } stateT;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_cycle_cnt.sv
// Loadable down-counter with zero flag for the muldiv iteration count.
// Decrements only while nonzero, so it can never wrap.
module muldiv_cycle_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Sequencer for the iterative mul/div unit in the E stage.
// Issues, steps the unit, strobes HI/LO and raises pipeline stalls.
module muldiv_seq_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic muldiv_enE,
  input  logic mul0_div1_selE,
  input  logic signed_opE,
  input  logic flushE,
  input  logic divisor_zeroE,
  input  logic hilo_rdD,
  output logic muldiv_enE_qual,
  output logic start,
  output logic step_en,
  output logic op_div,
  output logic op_signed,
  output logic hilo_we,
  output logic hilo_read_done,
  output logic div0_flag,
  output logic stall_muldivE,
  output logic stall_hiloD,
  output logic busy
);

  stateT state;
  stateT stateNext;

  logic             acc;
  logic             divZero;
  logic             zFlag;
  logic             cntLoad;
  logic [CNT_W-1:0] cntLoadVal;
  logic [CNT_W-1:0] cnt;
  logic             cntZero;
  logic             inRun;
  logic             inWb;

  assign inRun   = (state == RUN);
  assign inWb    = (state == WB);
  // Gated by rst so every output is quiet while reset is held.
  assign acc     = muldiv_enE & ~flushE & ~rst
                 & ((state == IDLE) | inWb);
  assign divZero = (mul0_div1_selE == OP_DIV) & divisor_zeroE;

  muldiv_cycle_cnt #(
    .CNT_W(CNT_W)
  ) uCnt (
    .clk    (clk),
    .rst    (rst),
    .load   (cntLoad),
    .loadVal(cntLoadVal),
    .dec    (inRun),
    .cnt    (cnt),
    .zero   (cntZero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_div    <= 1'b0;
      op_signed <= 1'b0;
      zFlag     <= 1'b0;
    end else begin
      state <= stateNext;
      if (acc) begin
        op_div    <= mul0_div1_selE;
        op_signed <= signed_opE;
        zFlag     <= divZero;
      end
    end
  end

  always_comb begin
    stateNext  = state;
    cntLoad    = 1'b0;
    cntLoadVal = '0;
    unique case (state)
      IDLE:    stateNext = IDLE;
      RUN:     stateNext = cntZero ? WB : RUN;
      WB:      stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (acc) begin
      if (divZero) begin
        stateNext = WB;
      end else begin
        cntLoad    = 1'b1;
        cntLoadVal = mul0_div1_selE ? CNT_W'(DIV_CYCLES - 1)
                                    : CNT_W'(MUL_CYCLES - 1);
        stateNext  = RUN;
      end
    end
  end

  assign muldiv_enE_qual = acc;
  assign start           = acc;
  assign step_en         = inRun;
  assign hilo_we         = inWb & ~zFlag;
  assign div0_flag       = inWb & zFlag;
  assign hilo_read_done  = inWb;
  assign busy            = (state != IDLE);
  assign stall_muldivE   = muldiv_enE & ~flushE & inRun;
  // WB needs no read stall: the write lands at this edge.
  assign stall_hiloD     = hilo_rdD & (inRun | acc);

  logic unusedCnt;
  assign unusedCnt = ^cnt;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Randomized scoreboard bench for muldiv_seq_ctrl.
// Model tracks the cycle the outstanding result is due.
module tb_muldiv_seq_ctrl;

  localparam int MULN = 4;
  localparam int DIVN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic muldiv_enE = 1'b0;
  logic mul0_div1_selE = 1'b0;
  logic signed_opE = 1'b0;
  logic flushE = 1'b0;
  logic divisor_zeroE = 1'b0;
  logic hilo_rdD = 1'b0;
  logic muldiv_enE_qual, start, step_en, op_div, op_signed;
  logic hilo_we, hilo_read_done, div0_flag;
  logic stall_muldivE, stall_hiloD, busy;

  muldiv_seq_ctrl #(
    .MUL_CYCLES(MULN),
    .DIV_CYCLES(DIVN),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .muldiv_enE(muldiv_enE),
    .mul0_div1_selE(mul0_div1_selE),
    .signed_opE(signed_opE),
    .flushE(flushE),
    .divisor_zeroE(divisor_zeroE),
    .hilo_rdD(hilo_rdD),
    .muldiv_enE_qual(muldiv_enE_qual),
    .start(start),
    .step_en(step_en),
    .op_div(op_div),
    .op_signed(op_signed),
    .hilo_we(hilo_we),
    .hilo_read_done(hilo_read_done),
    .div0_flag(div0_flag),
    .stall_muldivE(stall_muldivE),
    .stall_hiloD(stall_hiloD),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit z;
    bit div;
    bit sgn;
  } expT;

  expT sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  wbCyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0b exp=%0b", name, cyc, act, exp);
    end
  endtask

  task automatic chkInt(input string name, input int act,
                        input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: one result outstanding, due at wbCyc.
  always @(negedge clk) begin
    bit outst, inRun, accE, zE;
    expT e;
    if (rst) begin
      chk("rst_busy", busy, 1'b0);
      chk("rst_start", start, 1'b0);
      chk("rst_step", step_en, 1'b0);
      chk("rst_opdiv", op_div, 1'b0);
      chk("rst_stall", stall_hiloD | stall_muldivE, 1'b0);
      wbCyc = -1;
      sb.delete();
    end else begin
      outst = (wbCyc >= cyc);
      inRun = outst && (cyc < wbCyc);
      accE  = muldiv_enE && !flushE && !inRun;
      chk("qual", muldiv_enE_qual, accE);
      chk("start", start, accE);
      chk("step_en", step_en, inRun);
      chk("busy", busy, outst);
      chk("stall_muldivE", stall_muldivE,
          muldiv_enE && !flushE && inRun);
      chk("stall_hiloD", stall_hiloD, hilo_rdD && (inRun || accE));
      if (accE) begin
        zE    = mul0_div1_selE && divisor_zeroE;
        wbCyc = cyc + (zE ? 1 : ((mul0_div1_selE ? DIVN : MULN) + 1));
        e.cyc = wbCyc;
        e.z   = zE;
        e.div = mul0_div1_selE;
        e.sgn = signed_opE;
        sb.push_back(e);
      end else if (outst && !inRun) begin
        wbCyc = -1;
      end
    end
  end

  // Monitor: every HI/LO completion must match the oldest issue.
  always @(negedge clk) begin
    expT e;
    if (!rst) begin
      if (hilo_read_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_wb", hilo_read_done, 1'b0);
        end else begin
          e = sb.pop_front();
          chkInt("wb_cycle", cyc, e.cyc);
          chk("hilo_we", hilo_we, !e.z);
          chk("div0_flag", div0_flag, e.z);
          chk("op_div", op_div, e.div);
          chk("op_signed", op_signed, e.sgn);
        end
      end else begin
        chk("idle_we", hilo_we | div0_flag, 1'b0);
      end
    end
  end

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    muldiv_enE = 0;
    flushE = 0;
    divisor_zeroE = 0;
    hilo_rdD = 0;
    repeat (n) cyc1();
  endtask

  task automatic issue(input bit sel, input bit sgn, input bit dz);
    muldiv_enE = 1;
    mul0_div1_selE = sel;
    signed_opE = sgn;
    divisor_zeroE = dz;
  endtask

  initial begin
    repeat (3) cyc1();
    rst = 0;
    idle(2);
    // MULT
    issue(0, 1, 0); cyc1();
    idle(8);
    // DIVU with MFHI waiting in D
    issue(1, 0, 0); cyc1();
    idle(1);
    hilo_rdD = 1;
    repeat (35) cyc1();
    idle(2);
    // DIV by zero
    issue(1, 1, 1); cyc1();
    idle(4);
    // MULT then DIV held until accepted in MULT WB
    issue(0, 0, 0); cyc1();
    issue(1, 1, 0);
    repeat (5) cyc1();
    idle(40);
    // Flush in IDLE, then flush during RUN
    issue(0, 1, 0); flushE = 1;
    repeat (2) cyc1();
    idle(1);
    issue(1, 0, 0); cyc1();
    muldiv_enE = 0; flushE = 1;
    repeat (5) cyc1();
    idle(35);
    // Async reset in the middle of a DIV
    issue(1, 1, 0); cyc1();
    idle(10);
    #2 rst = 1;
    #1;
    chk("async_busy", busy, 1'b0);
    chk("async_step", step_en, 1'b0);
    chk("async_opdiv", op_div, 1'b0);
    chk("async_opsgn", op_signed, 1'b0);
    cyc1();
    rst = 0;
    idle(3);
    issue(0, 0, 0); cyc1();
    idle(8);
    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      muldiv_enE     = ($urandom_range(0, 3) == 0);
      mul0_div1_selE = $urandom_range(0, 1);
      signed_opE     = $urandom_range(0, 1);
      flushE         = ($urandom_range(0, 7) == 0);
      divisor_zeroE  = ($urandom_range(0, 5) == 0);
      hilo_rdD       = ($urandom_range(0, 2) == 0);
      cyc1();
    end
    idle(DIVN + 8);
    chkInt("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
